i2c_cmd_sequencer: RTL

Transaction sequencer sitting directly upstream of the bit-level I2C master. It buffers outgoing write bytes in a small FIFO, accepts one write command at a time (7-bit target address plus byte count), and drives the master byte by byte through start/data/stop handshakes. It retries on address NACK, aborts on data NACK, and reports completion or error to the host side.

---
 rtl/i2c_cmd_sequencer_pkg.sv | 28 ++
 rtl/i2c_cmd_sequencer_if.sv | 57 +++++
 rtl/i2c_byte_fifo.sv | 65 ++++++
 rtl/i2c_cmd_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg -- shared types and constants for the I2C command sequencer slice.
//   ADDR_W      : width of a 7-bit I2C target address
//   ACK / NACK  : SDA level sampled in the acknowledge slot
//   byte_t      : one data byte
//   seq_state_e : sequencer FSM states
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int ADDR_W = 7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_AACK,
        ST_SEND,
        ST_WAIT_DACK,
        ST_STOP,
        ST_WAIT_IDLE,
        ST_FLUSH
    } seq_state_e;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer_if -- host-side and master-side handshake bundle of the
// I2C command sequencer.
//   host   : wr_valid/wr_ready/wr_data (byte FIFO push),
//            cmd_valid/cmd_ready/cmd_addr/cmd_len (write command)
//   master : m_start/m_addr/m_rw/m_data/m_data_valid/m_data_take,
//            m_addr_ack/m_data_ack/m_ack_bit/m_stop/m_idle
//   status : busy, done, err, retry_cnt
// Modports:
//   slave  : the sequencer's view
//   master : the environment's view (host + bit-level master)
// ---------------------------------------------------------------------------
interface i2c_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    import i2c_pkg::*;

    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic              wr_valid;
    logic              wr_ready;
    byte_t             wr_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              m_start;
    logic [ADDR_W-1:0] m_addr;
    logic              m_rw;
    byte_t             m_data;
    logic              m_data_valid;
    logic              m_data_take;
    logic              m_addr_ack;
    logic              m_data_ack;
    logic              m_ack_bit;
    logic              m_stop;
    logic              m_idle;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        retry_cnt;

    modport slave (
        input  wr_valid, wr_data, cmd_valid, cmd_addr, cmd_len,
               m_data_take, m_addr_ack, m_data_ack, m_ack_bit, m_idle,
        output wr_ready, cmd_ready, m_start, m_addr, m_rw, m_data,
               m_data_valid, m_stop, busy, done, err, retry_cnt
    );

    modport master (
        output wr_valid, wr_data, cmd_valid, cmd_addr, cmd_len,
               m_data_take, m_addr_ack, m_data_ack, m_ack_bit, m_idle,
        input  wr_ready, cmd_ready, m_start, m_addr, m_rw, m_data,
               m_data_valid, m_stop, busy, done, err, retry_cnt
    );

endinterface

// File: rtl/i2c_byte_fifo.sv
// ---------------------------------------------------------------------------
// i2c_byte_fifo -- DEPTH x 8 synchronous FIFO with occupancy count.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write request and byte (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_data         : head byte, forced to 0 while empty
//   o_count        : entries held, 0..DEPTH
//   o_full/o_empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module i2c_byte_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  byte_t                  i_data,
    input  logic                   i_pop,
    output byte_t                  o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    byte_t              r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    // Full blocks a push even if a pop happens in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PTR_W+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    // Storage carries no reset; o_data is masked while empty instead.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer -- write-transaction sequencer in front of a bit-level
// I2C master. Buffers host bytes, accepts one write command at a time and
// walks the master through START / address / data / STOP, retrying the
// address phase on NACK and aborting on a data NACK.
//   i2c_clk : sole clock, rising edge
//   reset   : asynchronous, active-low
//   bus     : i2c_cmd_sequencer_if.slave (host, master and status signals)
// Parameters:
//   DEPTH     : FIFO bytes, power of two 2..16
//   MAX_RETRY : address re-attempts after the first NACK (fits retry_cnt)
// ---------------------------------------------------------------------------
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                  i2c_clk,
    input  logic                  reset,
    i2c_cmd_sequencer_if.slave    bus
);

    localparam int         LEN_W     = $clog2(DEPTH) + 1;
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

    seq_state_e         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic [1:0]         r_retry;
    logic               r_abort;
    logic               r_start;
    logic               r_stop;
    logic               r_dv;
    logic               r_done;
    logic               r_err;
    logic               r_busy;
    logic               r_armed;

    logic [LEN_W-1:0]   w_fifo_count;
    logic               w_full;
    logic               w_empty;
    byte_t              w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_dv;
    logic               w_take;
    logic               w_flush;
    logic               w_cmd_ready;
    logic               w_accept;

    i2c_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i2c_clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (bus.wr_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push  = bus.wr_valid && !w_full;
    assign w_dv    = r_dv && !w_empty;
    assign w_take  = (r_state == ST_SEND) && w_dv && bus.m_data_take;
    assign w_flush = (r_state == ST_FLUSH) && (r_remaining != '0);
    assign w_pop   = w_take || w_flush;

    // r_armed keeps cmd_ready low while reset is held and for the first
    // cycle after release, so every output starts from 0.
    assign w_cmd_ready = r_armed && (r_state == ST_IDLE) && bus.m_idle &&
                         (w_fifo_count >= bus.cmd_len);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;

    assign bus.wr_ready     = !w_full;
    assign bus.cmd_ready    = w_cmd_ready;
    assign bus.m_start      = r_start;
    assign bus.m_addr       = r_addr;
    assign bus.m_rw         = 1'b0;
    assign bus.m_data       = w_head;
    assign bus.m_data_valid = w_dv;
    assign bus.m_stop       = r_stop;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.retry_cnt    = r_retry;

    // Pulse outputs are set on the transition into the state they belong
    // to, so each one is high for exactly the cycle that state occupies.
    always_ff @(posedge i2c_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_retry     <= '0;
            r_abort     <= 1'b0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_dv        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= bus.cmd_addr;
                        r_remaining <= bus.cmd_len;
                        r_retry     <= '0;
                        r_abort     <= 1'b0;
                        r_start     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end
                end

                ST_START: begin
                    r_state <= ST_WAIT_AACK;
                end

                ST_WAIT_AACK: begin
                    if (bus.m_addr_ack) begin
                        if (bus.m_ack_bit == ACK) begin
                            if (r_remaining != '0) begin
                                r_dv    <= 1'b1;
                                r_state <= ST_SEND;
                            end else begin
                                r_stop  <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else if (r_retry < RETRY_MAX) begin
                            r_retry <= r_retry + 2'd1;
                            r_start <= 1'b1;
                            r_state <= ST_START;
                        end else begin
                            r_abort <= 1'b1;
                            r_stop  <= 1'b1;
                            r_state <= ST_STOP;
                        end
                    end
                end

                ST_SEND: begin
                    if (w_take) begin
                        r_dv        <= 1'b0;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_state     <= ST_WAIT_DACK;
                    end
                end

                ST_WAIT_DACK: begin
                    if (bus.m_data_ack) begin
                        if (bus.m_ack_bit == NACK) begin
                            r_abort <= 1'b1;
                            r_stop  <= 1'b1;
                            r_state <= ST_STOP;
                        end else if (r_remaining != '0) begin
                            r_dv    <= 1'b1;
                            r_state <= ST_SEND;
                        end else begin
                            r_stop  <= 1'b1;
                            r_state <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    r_state <= ST_WAIT_IDLE;
                end

                ST_WAIT_IDLE: begin
                    if (bus.m_idle) begin
                        if (r_remaining != '0) begin
                            // Unsent bytes only remain after an abort.
                            r_err   <= 1'b1;
                            r_state <= ST_FLUSH;
                        end else begin
                            r_done  <= !r_abort;
                            r_err   <= r_abort;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (r_remaining != '0)
                        r_remaining <= r_remaining - LEN_W'(1);
                    if (r_remaining <= LEN_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
